// File: rtl/cardinal_output_arbiter.sv
// Output-channel controller for one cardinal ring router port.
// Two virtual channels (even/odd) each hold one packet. The router-wide
// polarity bit picks which VC may accept a new packet (fill) and which VC
// may put its packet on the link (drain). A VC is never filled and drained
// in the same cycle. Two requesters (A, B) share each VC, and a per-VC
// round-robin pointer breaks ties between them.
module cardinal_output_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  req_a_even,
    input  logic                  req_a_odd,
    input  logic                  req_b_even,
    input  logic                  req_b_odd,
    input  logic [DATA_WIDTH-1:0] data_a_even,
    input  logic [DATA_WIDTH-1:0] data_a_odd,
    input  logic [DATA_WIDTH-1:0] data_b_even,
    input  logic [DATA_WIDTH-1:0] data_b_odd,
    output logic                  gnt_a_even,
    output logic                  gnt_a_odd,
    output logic                  gnt_b_even,
    output logic                  gnt_b_odd,
    output logic                  so,
    input  logic                  ro,
    output logic [DATA_WIDTH-1:0] dout
);

    // VC index 0 is even, index 1 is odd.
    logic [1:0]                  req_a;
    logic [1:0]                  req_b;
    logic [1:0][DATA_WIDTH-1:0]  data_a;
    logic [1:0][DATA_WIDTH-1:0]  data_b;

    assign req_a  = {req_a_odd, req_a_even};
    assign req_b  = {req_b_odd, req_b_even};
    assign data_a = {data_a_odd, data_a_even};
    assign data_b = {data_b_odd, data_b_even};

    // polarity=0 drains even and fills odd; polarity=1 the reverse.
    logic drain_vc;
    logic fill_vc;

    assign drain_vc = polarity;
    assign fill_vc  = ~polarity;

    // Per-VC results collected from the generate loop.
    logic [1:0]                  grant_a;
    logic [1:0]                  grant_b;
    logic [1:0]                  drain_fire;
    logic [1:0]                  full_vc;
    logic [1:0][DATA_WIDTH-1:0]  slot_vc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            logic                  full_reg;
            logic                  ptr_reg;
            logic [DATA_WIDTH-1:0] buf_reg;
            logic                  fill_open;
            logic                  grant_any;

            // This VC may accept a packet only in its fill phase, while empty
            // and out of reset.
            assign fill_open = !rst && (fill_vc == 1'(gi)) && !full_reg;

            // A lone requester always wins; on contention the pointer decides
            // (ptr=0 favours A, ptr=1 favours B).
            assign grant_a[gi] = fill_open && req_a[gi] && (!req_b[gi] || !ptr_reg);
            assign grant_b[gi] = fill_open && req_b[gi] && (!req_a[gi] ||  ptr_reg);
            assign grant_any   = grant_a[gi] || grant_b[gi];

            // The drain-phase VC sends when it holds a packet and the link is ready.
            assign drain_fire[gi] = (drain_vc == 1'(gi)) && full_reg && ro;

            assign full_vc[gi] = full_reg;
            assign slot_vc[gi] = buf_reg;

            // Occupancy and round-robin pointer; the pointer moves to the loser
            // on every grant, contended or not.
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_reg <= 1'b0;
                    ptr_reg  <= 1'b0;
                end else if (grant_any) begin
                    full_reg <= 1'b1;
                    ptr_reg  <= grant_a[gi];
                end else if (drain_fire[gi]) begin
                    full_reg <= 1'b0;
                end
            end

            // Packet storage; contents are meaningless while full_reg is clear,
            // so the buffer itself needs no reset.
            always_ff @(posedge clk) begin
                if (grant_any) begin
                    buf_reg <= grant_a[gi] ? data_a[gi] : data_b[gi];
                end
            end
        end
    endgenerate

    // Registered link interface: strobe for one cycle per sent packet, data
    // holds its last value between sends.
    logic                  so_reg;
    logic [DATA_WIDTH-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            so_reg   <= 1'b0;
            dout_reg <= '0;
        end else if (|drain_fire) begin
            so_reg   <= 1'b1;
            dout_reg <= slot_vc[drain_vc];
        end else begin
            so_reg   <= 1'b0;
        end
    end

    assign so   = so_reg;
    assign dout = dout_reg;

    assign gnt_a_even = grant_a[0];
    assign gnt_a_odd  = grant_a[1];
    assign gnt_b_even = grant_b[0];
    assign gnt_b_odd  = grant_b[1];

endmodule

// File: tb/tb_cardinal_output_arbiter.sv
// Bench for cardinal_output_arbiter: directed phases plus a per-VC slot model
// compared on every falling edge.
module tb_cardinal_output_arbiter;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          polarity;
    logic          req_a_even, req_a_odd, req_b_even, req_b_odd;
    logic [DW-1:0] data_a_even, data_a_odd, data_b_even, data_b_odd;
    logic          gnt_a_even, gnt_a_odd, gnt_b_even, gnt_b_odd;
    logic          so;
    logic          ro;
    logic [DW-1:0] dout;
    logic [3:0]    gnts;

    assign gnts = {gnt_b_odd, gnt_b_even, gnt_a_odd, gnt_a_even};

    cardinal_output_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .polarity   (polarity),
        .req_a_even (req_a_even),
        .req_a_odd  (req_a_odd),
        .req_b_even (req_b_even),
        .req_b_odd  (req_b_odd),
        .data_a_even(data_a_even),
        .data_a_odd (data_a_odd),
        .data_b_even(data_b_even),
        .data_b_odd (data_b_odd),
        .gnt_a_even (gnt_a_even),
        .gnt_a_odd  (gnt_a_odd),
        .gnt_b_even (gnt_b_even),
        .gnt_b_odd  (gnt_b_odd),
        .so         (so),
        .ro         (ro),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each VC is a one-packet slot with an owner-priority bit.
    logic          m_full [2];
    logic          m_ptr  [2];
    logic [DW-1:0] m_slot [2];
    logic          m_so;
    logic [DW-1:0] m_dout;

    function automatic logic req_of(input int r, input int v);
        if (r == 0) return (v == 0) ? req_a_even : req_a_odd;
        return (v == 0) ? req_b_even : req_b_odd;
    endfunction

    function automatic logic [DW-1:0] data_of(input int r, input int v);
        if (r == 0) return (v == 0) ? data_a_even : data_a_odd;
        return (v == 0) ? data_b_even : data_b_odd;
    endfunction

    // Who gets VC v right now: -1 nobody, 0 A, 1 B.
    function automatic int winner(input int v);
        int fill;
        fill = polarity ? 0 : 1;
        if (rst !== 1'b0 || v != fill || m_full[v]) return -1;
        if (req_of(0, v) && req_of(1, v)) return m_ptr[v] ? 1 : 0;
        if (req_of(0, v)) return 0;
        if (req_of(1, v)) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin : model_step
        int w, d, p;
        if (rst) begin
            m_full[0] <= 1'b0; m_full[1] <= 1'b0;
            m_ptr[0]  <= 1'b0; m_ptr[1]  <= 1'b0;
            m_so      <= 1'b0;
            m_dout    <= '0;
        end else begin
            w = polarity ? 0 : 1;
            d = 1 - w;
            p = winner(w);
            if (p >= 0) begin
                m_slot[w] <= data_of(p, w);
                m_full[w] <= 1'b1;
                m_ptr[w]  <= (p == 0);
            end
            if (m_full[d] && ro) begin
                m_so      <= 1'b1;
                m_dout    <= m_slot[d];
                m_full[d] <= 1'b0;
            end else begin
                m_so <= 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        logic [3:0] exp_g;
        exp_g = {winner(1) == 1, winner(0) == 1, winner(1) == 0, winner(0) == 0};
        chk("model_gnt", gnts, exp_g);
        chk("model_so", so, m_so);
        chk("model_dout", dout, m_dout);
    end

    // ---------------- stimulus ----------------
    // Advance one cycle; polarity sits at 1 in reset so the first free cycle is 0.
    task automatic tick(input logic r);
        @(posedge clk);
        #1;
        rst      = r;
        polarity = r ? 1'b1 : ~polarity;
    endtask

    initial begin
        rst = 1'b1; polarity = 1'b1; ro = 1'b1;
        req_a_even = 1'b1; req_a_odd = 1'b1; req_b_even = 1'b1; req_b_odd = 1'b1;
        data_a_even = 64'h0000_0000_0000_A0A0;
        data_a_odd  = 64'h0000_0000_0000_1111;
        data_b_even = 64'h0000_0000_0000_2222;
        data_b_odd  = 64'h0000_0000_0000_3333;

        // Reset with everything requesting.
        #2; chk("rst_gnt0", gnts, 4'b0000);
        tick(1'b1); #1;
        chk("rst_gnt1", gnts, 4'b0000);
        chk("rst_so", so, 1'b0);
        chk("rst_dout", dout, 64'h0);
        tick(1'b0); #1;
        chk("post_rst_gnt", gnts, 4'b0010);
        chk("post_rst_so", so, 1'b0);
        tick(1'b0);
        req_a_even = 1'b0; req_a_odd = 1'b0; req_b_even = 1'b0; req_b_odd = 1'b0;
        #1; chk("first_idle_so", so, 1'b0);
        tick(1'b0); #1;
        chk("first_send_so", so, 1'b1);
        chk("first_send_dout", dout, 64'h1111);

        // Single packet on the even VC.
        tick(1'b0);
        req_a_even = 1'b1; data_a_even = 64'h8000_0000_0000_00AA;
        #1; chk("single_gnt", gnts, 4'b0001);
        tick(1'b0);
        req_a_even = 1'b0;
        #1; chk("single_wait_so", so, 1'b0);
        tick(1'b0); #1;
        chk("single_so", so, 1'b1);
        chk("single_dout", dout, 64'h8000_0000_0000_00AA);
        tick(1'b0); #1;
        chk("single_so_low", so, 1'b0);

        // Contention on the odd VC from a clean reset.
        tick(1'b1);
        tick(1'b0);
        req_a_odd = 1'b1; req_b_odd = 1'b1;
        data_a_odd = 64'h0A; data_b_odd = 64'h0B; ro = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_gnt", {gnt_a_odd, gnt_b_odd}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0) begin
                chk("cont_so", so, 1'b1);
                chk("cont_dout", dout, (k % 2 == 1) ? 64'h0A : 64'h0B);
            end
            tick(1'b0);
            if (k == 3) begin
                req_a_odd = 1'b0; req_b_odd = 1'b0;
            end
            #1; chk("cont_drain_phase_gnt", gnts, 4'b0000);
            tick(1'b0);
        end
        #1;
        chk("cont_last_so", so, 1'b1);
        chk("cont_last_dout", dout, 64'h0B);

        // Backpressure on the even VC.
        tick(1'b0);
        req_a_even = 1'b1; data_a_even = 64'hBEEF; ro = 1'b0;
        #1; chk("bp_fill_gnt", gnts, 4'b0001);
        tick(1'b0);
        req_a_even = 1'b0; req_b_even = 1'b1; data_b_even = 64'hB0B0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("bp_so", so, 1'b0);
            chk("bp_gnt_b_even", gnt_b_even, 1'b0);
            tick(1'b0);
        end
        ro = 1'b1;
        #1; chk("bp_release_gnt", gnt_b_even, 1'b0);
        tick(1'b0); #1;
        chk("bp_send_so", so, 1'b1);
        chk("bp_send_dout", dout, 64'hBEEF);
        chk("bp_refill_gnt", gnt_b_even, 1'b1);
        tick(1'b0);
        req_b_even = 1'b0;
        tick(1'b0); #1;
        chk("bp_second_dout", dout, 64'hB0B0);

        // Reset while both buffers hold packets.
        ro = 1'b0;
        req_a_even = 1'b1; data_a_even = 64'hDEAD;
        #1; chk("mid_fill_even", gnts, 4'b0001);
        tick(1'b0);
        req_a_even = 1'b0; req_b_odd = 1'b1; data_b_odd = 64'hFACE;
        #1; chk("mid_fill_odd", gnts, 4'b1000);
        tick(1'b0);
        req_b_odd = 1'b0;
        #1; chk("mid_held_so", so, 1'b0);
        tick(1'b1); #1;
        chk("mid_rst_gnt", gnts, 4'b0000);
        tick(1'b0);
        ro = 1'b1;
        #1;
        chk("mid_after_so", so, 1'b0);
        chk("mid_after_dout", dout, 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0); #1;
            chk("mid_no_stale_so", so, 1'b0);
        end

        // Even requests only in the even drain phase never get granted.
        for (int k = 0; k < 6; k++) begin
            tick(1'b0);
            req_a_even = ~polarity;
            #1; chk("phase_iso_gnt", gnt_a_even, 1'b0);
        end
        req_a_even = 1'b0;
        tick(1'b0);
        tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
